// File: rtl/srl_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : srl_issue_pkg
// Description : Shared constants and helpers for the srl issue stage:
//               shift-amount width rule and the over-range predicate.
// Revision    : 1.0 - initial release
// ============================================================================
package srl_issue_pkg;

    // Shift-amount port width for a given word width: log2 bits plus one
    // extra bit so that amounts up to 2*width-1 can be presented.
    function automatic int AMT_W(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

    // A shift is over-range when it moves every bit out of the word.
    function automatic logic is_over_range(input logic [31:0] amount,
                                           input logic [31:0] width);
        return (amount >= width);
    endfunction

endpackage : srl_issue_pkg
`default_nettype wire

// File: rtl/srl.sv
`default_nettype none
// ============================================================================
// Module      : srl
// Description : Combinational logical right shift, zero fill. Amounts at or
//               above the word width produce an all-zero result.
// Revision    : 1.0 - initial release
// ============================================================================
module srl
    import srl_issue_pkg::*;
#(
    parameter  int p_DATA_WIDTH     = 8,
    localparam int lp_SFT_AMT_WIDTH = $clog2(p_DATA_WIDTH)
) (
    input  logic [p_DATA_WIDTH-1:0]   i_INPUT,
    input  logic [lp_SFT_AMT_WIDTH:0] i_SHIFT_AMOUNT,
    output logic [p_DATA_WIDTH-1:0]   o_RESULT
);

    logic w_over;

    assign w_over = is_over_range(32'(i_SHIFT_AMOUNT), 32'(p_DATA_WIDTH));

    // Only the low log2 bits matter once over-range is handled explicitly.
    assign o_RESULT = w_over ? '0
                             : (i_INPUT >> i_SHIFT_AMOUNT[lp_SFT_AMT_WIDTH-1:0]);

endmodule : srl
`default_nettype wire

// File: rtl/srl_issue.sv
`default_nettype none
// ============================================================================
// Module      : srl_issue
// Description : Flow-controlled issue stage around the srl unit. Registered
//               result, one-entry skid buffer holding raw operands, registered
//               input ready, and a saturating counter of over-range operands.
// Revision    : 1.0 - initial release
// ============================================================================
module srl_issue
    import srl_issue_pkg::*;
#(
    parameter  int p_DATA_WIDTH     = 8,
    parameter  int p_CNT_WIDTH      = 8,
    localparam int lp_SFT_AMT_WIDTH = $clog2(p_DATA_WIDTH)
) (
    input  logic                      i_CLK,
    input  logic                      i_RST_N,
    input  logic                      i_IN_VALID,
    output logic                      o_IN_READY,
    input  logic [p_DATA_WIDTH-1:0]   i_INPUT,
    input  logic [lp_SFT_AMT_WIDTH:0] i_SHIFT_AMOUNT,
    output logic                      o_OUT_VALID,
    input  logic                      i_OUT_READY,
    output logic [p_DATA_WIDTH-1:0]   o_RESULT,
    output logic                      o_OVER_RANGE,
    output logic [p_CNT_WIDTH-1:0]    o_OVR_COUNT
);

    localparam int lp_AMT_W = AMT_W(p_DATA_WIDTH);

    // Raw operand parked while the output register is stalled.
    typedef struct packed {
        logic [p_DATA_WIDTH-1:0] data;
        logic [lp_AMT_W-1:0]     amount;
    } skid_entry_t;

    logic                    r_out_valid;
    logic [p_DATA_WIDTH-1:0] r_result;
    logic                    r_over;
    logic                    r_skid_valid;
    skid_entry_t             r_skid;
    logic [p_CNT_WIDTH-1:0]  r_ovr_count;

    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_out_free;
    logic                    w_load_out;
    logic [p_DATA_WIDTH-1:0] w_src_data;
    logic [lp_AMT_W-1:0]     w_src_amt;
    logic [p_DATA_WIDTH-1:0] w_shifted;
    logic                    w_src_over;
    logic                    w_in_over;

    // Ready depends only on skid occupancy (a register); reset gates it low.
    assign w_in_ready = i_RST_N & ~r_skid_valid;
    assign w_accept   = i_IN_VALID & w_in_ready;
    assign w_out_free = ~r_out_valid | i_OUT_READY;

    // A full skid always drains first, which keeps delivery strictly in order.
    // While the skid is full, ready is low so no new operand competes.
    assign w_src_data = r_skid_valid ? r_skid.data   : i_INPUT;
    assign w_src_amt  = r_skid_valid ? r_skid.amount : i_SHIFT_AMOUNT;
    assign w_load_out = w_out_free & (r_skid_valid | w_accept);

    assign w_src_over = is_over_range(32'(w_src_amt), 32'(p_DATA_WIDTH));
    assign w_in_over  = is_over_range(32'(i_SHIFT_AMOUNT), 32'(p_DATA_WIDTH));

    srl #(
        .p_DATA_WIDTH   (p_DATA_WIDTH)
    ) u_srl (
        .i_INPUT        (w_src_data),
        .i_SHIFT_AMOUNT (w_src_amt),
        .o_RESULT       (w_shifted)
    );

    // Output register and skid entry: load, park, drain or empty each edge.
    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            r_out_valid  <= 1'b0;
            r_result     <= '0;
            r_over       <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid       <= '0;
        end else if (w_out_free) begin
            if (w_load_out) begin
                r_out_valid  <= 1'b1;
                r_result     <= w_shifted;
                r_over       <= w_src_over;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid  <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_valid  <= 1'b1;
            r_skid.data   <= i_INPUT;
            r_skid.amount <= i_SHIFT_AMOUNT;
        end
    end

    // Count accepted over-range operands, holding at all-ones.
    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            r_ovr_count <= '0;
        end else if (w_accept && w_in_over && (r_ovr_count != {p_CNT_WIDTH{1'b1}})) begin
            r_ovr_count <= r_ovr_count + 1'b1;
        end
    end

    assign o_IN_READY   = w_in_ready;
    assign o_OUT_VALID  = r_out_valid;
    assign o_RESULT     = r_result;
    assign o_OVER_RANGE = r_over;
    assign o_OVR_COUNT  = r_ovr_count;

endmodule : srl_issue
`default_nettype wire

// File: tb/tb_srl_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_srl_issue
// Description : Self-checking bench for srl_issue. A queue-based reference
//               model predicts ready/valid/result/over-range/count; a second
//               instance with a 2-bit counter shares the stimulus to show
//               counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_srl_issue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic [3:0] in_amt;
    logic       out_ready;

    logic       o_in_ready;
    logic       o_out_valid;
    logic [7:0] o_result;
    logic       o_over;
    logic [7:0] o_count;

    logic       u2_in_ready;
    logic       u2_out_valid;
    logic [7:0] u2_result;
    logic       u2_over;
    logic [1:0] u2_count;

    always #5 clk = ~clk;

    srl_issue #(.p_DATA_WIDTH(8), .p_CNT_WIDTH(8)) dut (
        .i_CLK          (clk),
        .i_RST_N        (rst_n),
        .i_IN_VALID     (in_valid),
        .o_IN_READY     (o_in_ready),
        .i_INPUT        (in_data),
        .i_SHIFT_AMOUNT (in_amt),
        .o_OUT_VALID    (o_out_valid),
        .i_OUT_READY    (out_ready),
        .o_RESULT       (o_result),
        .o_OVER_RANGE   (o_over),
        .o_OVR_COUNT    (o_count)
    );

    srl_issue #(.p_DATA_WIDTH(8), .p_CNT_WIDTH(2)) dut2 (
        .i_CLK          (clk),
        .i_RST_N        (rst_n),
        .i_IN_VALID     (in_valid),
        .o_IN_READY     (u2_in_ready),
        .i_INPUT        (in_data),
        .i_SHIFT_AMOUNT (in_amt),
        .o_OUT_VALID    (u2_out_valid),
        .i_OUT_READY    (out_ready),
        .o_RESULT       (u2_result),
        .o_OVER_RANGE   (u2_over),
        .o_OVR_COUNT    (u2_count)
    );

    // Reference model: results waiting in the stage, oldest first.
    typedef struct {
        logic [7:0] res;
        logic       ovr;
    } exp_t;

    exp_t q[$];
    int   cnt8;
    int   cnt2;
    int   checks;
    int   passes;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Stage holds at most two operands; the predicted outputs follow from that.
    task automatic check_all(input logic rstn);
        chk("in_ready",  32'(o_in_ready),  32'(rstn && (q.size() < 2)));
        chk("out_valid", 32'(o_out_valid), 32'(q.size() > 0));
        if (!rstn) begin
            chk("result_rst", 32'(o_result), 32'd0);
            chk("over_rst",   32'(o_over),   32'd0);
        end else if (q.size() > 0) begin
            chk("result", 32'(o_result), 32'(q[0].res));
            chk("over",   32'(o_over),   32'(q[0].ovr));
        end
        chk("ovr_count",      32'(o_count),  32'(cnt8));
        chk("ovr_count_sat2", 32'(u2_count), 32'(cnt2));
    endtask

    // Apply one cycle of inputs, advance the model, then check after the edge.
    task automatic cycle(input logic rstn, input logic iv, input logic [7:0] d,
                         input logic [3:0] a, input logic ordy);
        exp_t e;
        logic accept;
        logic xfer;
        rst_n     = rstn;
        in_valid  = iv;
        in_data   = d;
        in_amt    = a;
        out_ready = ordy;
        if (!rstn) begin
            q.delete();
            cnt8 = 0;
            cnt2 = 0;
        end else begin
            accept = iv && (q.size() < 2);
            xfer   = (q.size() > 0) && ordy;
            if (xfer) void'(q.pop_front());
            if (accept) begin
                e.ovr = (a >= 4'd8);
                e.res = e.ovr ? 8'h00 : (d >> a);
                q.push_back(e);
                if (e.ovr) begin
                    if (cnt8 < 255) cnt8++;
                    if (cnt2 < 3)   cnt2++;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_all(rstn);
    endtask

    initial begin
        checks = 0;
        passes = 0;
        cnt8   = 0;
        cnt2   = 0;

        // Reset held three cycles, then released.
        repeat (3) cycle(1'b0, 1'b1, 8'h5A, 4'd1, 1'b1);
        cycle(1'b1, 1'b0, 8'h00, 4'd0, 1'b1);

        // Basic shifts including the pass-through amount.
        cycle(1'b1, 1'b1, 8'hB4, 4'd2, 1'b1);
        cycle(1'b1, 1'b1, 8'hB4, 4'd0, 1'b1);
        cycle(1'b1, 1'b0, 8'h00, 4'd0, 1'b1);

        // Back-to-back stream at full throughput.
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 8'h80, 4'(i), 1'b1);
        cycle(1'b1, 1'b0, 8'h00, 4'd0, 1'b1);

        // Stall: fill OUT and SKID, third operand refused, then drain in order.
        cycle(1'b1, 1'b1, 8'hFF, 4'd1, 1'b0);
        cycle(1'b1, 1'b1, 8'hF0, 4'd4, 1'b0);
        cycle(1'b1, 1'b1, 8'h33, 4'd3, 1'b0);
        cycle(1'b1, 1'b1, 8'h33, 4'd3, 1'b0);
        cycle(1'b1, 1'b0, 8'h00, 4'd0, 1'b1);
        cycle(1'b1, 1'b0, 8'h00, 4'd0, 1'b1);
        cycle(1'b1, 1'b0, 8'h00, 4'd0, 1'b1);

        // Over-range amounts; five in total saturate the 2-bit counter.
        cycle(1'b1, 1'b1, 8'hAA, 4'd8,  1'b1);
        cycle(1'b1, 1'b1, 8'hAA, 4'd15, 1'b1);
        cycle(1'b1, 1'b1, 8'hAA, 4'd9,  1'b1);
        cycle(1'b1, 1'b1, 8'hAA, 4'd12, 1'b1);
        cycle(1'b1, 1'b1, 8'hAA, 4'd8,  1'b1);
        cycle(1'b1, 1'b0, 8'h00, 4'd0,  1'b1);

        // Reset with OUT and SKID full: nothing stale may appear afterwards.
        cycle(1'b1, 1'b1, 8'hC3, 4'd1, 1'b0);
        cycle(1'b1, 1'b1, 8'h3C, 4'd9, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 4'd0, 1'b1);
        repeat (3) cycle(1'b1, 1'b0, 8'h00, 4'd0, 1'b1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 500; i++) begin
            cycle(($urandom_range(0, 63) != 0),
                  ($urandom_range(0, 3) != 0),
                  8'($urandom),
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 2) != 0));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_srl_issue
`default_nettype wire
